lsu_dccm_wr_ecc: RTL and testbench

- DCCM write-side engine, the encode/writeback counterpart of the DC3 load-path SEC/DED decode.
- Accepts store-buffer drain writes and single-bit-error corrected read data ("scrub" writebacks).
- Arbitrates between the two sources, computes SEC-DED check bits, and drives one registered DCCM write per cycle.
- Sits between lsu_stbuf / lsu_ecc and the DCCM write port.

---
 rtl/lsu_dccm_wr_ecc_if.sv | 42 ++++
 rtl/lsu_dccm_wr_ecc.sv | 128 ++++++++++++
 tb/tb_lsu_dccm_wr_ecc.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/lsu_dccm_wr_ecc_if.sv
// Signal bundle between the LSU write sources (store buffer, DC3 SEC correction)
// and the DCCM write-side ECC engine, including the engine's DCCM write port.
interface lsu_dccm_wr_ecc_if #(
  parameter int DCCM_BITS   = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int ECC_WIDTH   = 7,
  parameter int SCRUB_DEPTH = 2
);
  // Handshake: stbuf_wr_req is a level request that holds its addr/data until
  // stbuf_wr_ack is seen high in the same cycle; the write is committed on that edge.
  // sec_valid_dc3 is a single-cycle strobe with no back-pressure.
  logic                              dec_tlu_core_ecc_disable;
  logic                              dccm_wr_block;
  logic                              stbuf_wr_req;
  logic [DCCM_BITS-1:0]              stbuf_wr_addr;
  logic [DATA_WIDTH-1:0]             stbuf_wr_data;
  logic                              stbuf_wr_ack;
  logic                              sec_valid_dc3;
  logic [DCCM_BITS-1:0]              sec_addr_dc3;
  logic [DATA_WIDTH-1:0]             sec_data_dc3;
  logic                              dccm_wren;
  logic [DCCM_BITS-1:0]              dccm_wr_addr;
  logic [DATA_WIDTH+ECC_WIDTH-1:0]   dccm_wr_data;
  logic [$clog2(SCRUB_DEPTH):0]      scrub_pending;
  logic                              scrub_overflow;

  modport master (
    output dec_tlu_core_ecc_disable, dccm_wr_block,
    output stbuf_wr_req, stbuf_wr_addr, stbuf_wr_data,
    output sec_valid_dc3, sec_addr_dc3, sec_data_dc3,
    input  stbuf_wr_ack, dccm_wren, dccm_wr_addr, dccm_wr_data,
    input  scrub_pending, scrub_overflow
  );

  modport slave (
    input  dec_tlu_core_ecc_disable, dccm_wr_block,
    input  stbuf_wr_req, stbuf_wr_addr, stbuf_wr_data,
    input  sec_valid_dc3, sec_addr_dc3, sec_data_dc3,
    output stbuf_wr_ack, dccm_wren, dccm_wr_addr, dccm_wr_data,
    output scrub_pending, scrub_overflow
  );
endinterface

// File: rtl/lsu_dccm_wr_ecc.sv
// DCCM write-side engine: arbitrates store-buffer drains against SEC scrub
// writebacks, encodes SEC-DED check bits and registers one DCCM write per cycle.
module lsu_dccm_wr_ecc #(
  parameter int DCCM_BITS   = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int ECC_WIDTH   = 7,
  parameter int SCRUB_DEPTH = 2,
  parameter int STARVE_MAX  = 4
) (
  input logic                 clk,
  input logic                 rst,
  lsu_dccm_wr_ecc_if.slave    bus
);
  localparam int PW = $clog2(SCRUB_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  // Same masks as rvecc_encode; the check-bit layout is defined for 32-bit words.
  function automatic logic [6:0] ecc32(input logic [31:0] d);
    logic [6:0] c;
    c[0] = ^(d & 32'h56AAAD5B);
    c[1] = ^(d & 32'h9B33366D);
    c[2] = ^(d & 32'hE3C3C78E);
    c[3] = ^(d & 32'h03FC07F0);
    c[4] = ^(d & 32'h03FFF800);
    c[5] = ^(d & 32'hFC000000);
    c[6] = ^{d, c[5:0]};
    return c;
  endfunction

  logic [DCCM_BITS-1:0]            ent_addr_q [SCRUB_DEPTH];
  logic [DATA_WIDTH-1:0]           ent_data_q [SCRUB_DEPTH];
  logic [SCRUB_DEPTH-1:0]          ent_vld_q;
  logic [PW-1:0]                   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]                   count_q, count_d;
  logic [SW-1:0]                   starve_q, starve_d;
  logic                            overflow_q, overflow_d;
  logic                            wren_q;
  logic [DCCM_BITS-1:0]            wr_addr_q;
  logic [DATA_WIDTH+ECC_WIDTH-1:0] wr_data_q;

  logic                  q_empty, q_full;
  logic                  grant_scrub, grant_stbuf;
  logic                  dup_hit, capture, push;
  logic [DCCM_BITS-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [ECC_WIDTH-1:0]  sel_ecc;

  assign q_empty = (count_q == '0);
  assign q_full  = (count_q == CW'(SCRUB_DEPTH));

  // Scrub wins unless the store buffer has been passed over STARVE_MAX times in a row.
  assign grant_scrub = ~rst & ~bus.dccm_wr_block & ~q_empty &
                       ((starve_q < SW'(STARVE_MAX)) | ~bus.stbuf_wr_req);
  assign grant_stbuf = ~rst & ~bus.dccm_wr_block & bus.stbuf_wr_req & ~grant_scrub;

  always_comb begin
    dup_hit = 1'b0;
    for (int i = 0; i < SCRUB_DEPTH; i++) begin
      if (ent_vld_q[i] && (ent_addr_q[i] == bus.sec_addr_dc3)) dup_hit = 1'b1;
    end
  end

  // A store granted this cycle to the same word supersedes the corrected read data.
  assign capture = bus.sec_valid_dc3 & ~bus.dec_tlu_core_ecc_disable & ~dup_hit &
                   ~(grant_stbuf & (bus.stbuf_wr_addr == bus.sec_addr_dc3));
  assign push       = capture & (~q_full | grant_scrub);
  assign overflow_d = capture & q_full & ~grant_scrub;
  assign count_d    = count_q + CW'(push) - CW'(grant_scrub);

  always_comb begin
    starve_d = starve_q;
    if (!bus.dccm_wr_block) begin
      if (grant_stbuf || !bus.stbuf_wr_req) starve_d = '0;
      else if (grant_scrub && (starve_q < SW'(STARVE_MAX))) starve_d = starve_q + SW'(1);
    end
  end

  assign sel_addr = grant_scrub ? ent_addr_q[rd_ptr_q] : bus.stbuf_wr_addr;
  assign sel_data = grant_scrub ? ent_data_q[rd_ptr_q] : bus.stbuf_wr_data;
  // ECC uses the disable level at grant time, so queued entries follow later toggles.
  assign sel_ecc  = bus.dec_tlu_core_ecc_disable ? '0 : ECC_WIDTH'(ecc32(sel_data));

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr_q[wr_ptr_q] <= bus.sec_addr_dc3;
      ent_data_q[wr_ptr_q] <= bus.sec_data_dc3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_vld_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      overflow_q <= 1'b0;
      wren_q     <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      if (grant_scrub) begin
        ent_vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q            <= rd_ptr_q + PW'(1);
      end
      if (push) begin
        ent_vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q            <= wr_ptr_q + PW'(1);
      end
      count_q    <= count_d;
      starve_q   <= starve_d;
      overflow_q <= overflow_d;
      wren_q     <= grant_scrub | grant_stbuf;
      if (grant_scrub || grant_stbuf) begin
        wr_addr_q <= sel_addr;
        wr_data_q <= {sel_ecc, sel_data};
      end
    end
  end

  assign bus.stbuf_wr_ack   = grant_stbuf;
  assign bus.dccm_wren      = wren_q;
  assign bus.dccm_wr_addr   = wr_addr_q;
  assign bus.dccm_wr_data   = wr_data_q;
  assign bus.scrub_pending  = count_q;
  assign bus.scrub_overflow = overflow_q;
endmodule

// File: tb/tb_lsu_dccm_wr_ecc.sv
// Bench for lsu_dccm_wr_ecc: directed scenarios followed by random traffic,
// checked cycle by cycle against a queue-based reference model.
module tb_lsu_dccm_wr_ecc;
  localparam int DCCM_BITS   = 16;
  localparam int DATA_WIDTH  = 32;
  localparam int ECC_WIDTH   = 7;
  localparam int SCRUB_DEPTH = 2;
  localparam int STARVE_MAX  = 4;
  localparam int WW = DCCM_BITS + DATA_WIDTH + ECC_WIDTH;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  lsu_dccm_wr_ecc_if #(
    .DCCM_BITS(DCCM_BITS), .DATA_WIDTH(DATA_WIDTH),
    .ECC_WIDTH(ECC_WIDTH), .SCRUB_DEPTH(SCRUB_DEPTH)
  ) bus ();

  lsu_dccm_wr_ecc #(
    .DCCM_BITS(DCCM_BITS), .DATA_WIDTH(DATA_WIDTH), .ECC_WIDTH(ECC_WIDTH),
    .SCRUB_DEPTH(SCRUB_DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [DCCM_BITS+DATA_WIDTH-1:0] model_q[$];
  logic [WW-1:0]                   exp_q[$];
  int                              model_starve;
  logic [DCCM_BITS-1:0]            last_addr;
  logic [DATA_WIDTH+ECC_WIDTH-1:0] last_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Hamming positions 1..38: powers of two hold check bits, data fills the rest;
  // check bit i is the parity of data positions with bit i set, bit 6 the overall parity.
  function automatic logic [6:0] ref_ecc(input logic [31:0] d);
    logic [6:0] c;
    int k;
    c = '0;
    k = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[k]) c[5:0] = c[5:0] ^ p[5:0];
        k++;
      end
    end
    c[6] = (^d) ^ (^c[5:0]);
    return c;
  endfunction

  task automatic step(input logic r, input logic blk, input logic dis,
                      input logic req, input logic [15:0] sa, input logic [31:0] sd,
                      input logic sv, input logic [15:0] va, input logic [31:0] vd);
    logic win, ack, dup, e_wren, e_ovf;
    logic [DCCM_BITS+DATA_WIDTH-1:0] e;
    logic [WW-1:0] w;
    @(negedge clk);
    rst                          = r;
    bus.dccm_wr_block            = blk;
    bus.dec_tlu_core_ecc_disable = dis;
    bus.stbuf_wr_req             = req;
    bus.stbuf_wr_addr            = sa;
    bus.stbuf_wr_data            = sd;
    bus.sec_valid_dc3            = sv;
    bus.sec_addr_dc3             = va;
    bus.sec_data_dc3             = vd;
    #1;
    e_wren = 1'b0;
    e_ovf  = 1'b0;
    ack    = 1'b0;
    if (r) begin
      model_q.delete();
      exp_q.delete();
      model_starve = 0;
      last_addr    = '0;
      last_data    = '0;
    end else begin
      win = !blk && (model_q.size() != 0) && (model_starve < STARVE_MAX || !req);
      ack = !blk && req && !win;
      dup = 1'b0;
      foreach (model_q[i]) if (model_q[i][47:32] == va) dup = 1'b1;
      if (win) begin
        e = model_q.pop_front();
        exp_q.push_back({e[47:32], dis ? 7'h00 : ref_ecc(e[31:0]), e[31:0]});
        e_wren = 1'b1;
      end else if (ack) begin
        exp_q.push_back({sa, dis ? 7'h00 : ref_ecc(sd), sd});
        e_wren = 1'b1;
      end
      if (sv && !dis && !dup && !(ack && va == sa)) begin
        if (model_q.size() < SCRUB_DEPTH) model_q.push_back({va, vd});
        else e_ovf = 1'b1;
      end
      if (!blk) begin
        if (ack || !req) model_starve = 0;
        else if (win && model_starve < STARVE_MAX) model_starve++;
      end
    end
    check("stbuf_wr_ack", 64'(bus.stbuf_wr_ack), 64'(ack));
    @(posedge clk);
    #1;
    check("dccm_wren", 64'(bus.dccm_wren), 64'(e_wren));
    if (e_wren && exp_q.size() != 0) begin
      w = exp_q.pop_front();
      last_addr = w[WW-1:DATA_WIDTH+ECC_WIDTH];
      last_data = w[DATA_WIDTH+ECC_WIDTH-1:0];
    end
    check("dccm_wr_addr", 64'(bus.dccm_wr_addr), 64'(last_addr));
    check("dccm_wr_data", 64'(bus.dccm_wr_data), 64'(last_data));
    check("scrub_pending", 64'(bus.scrub_pending), 64'(model_q.size()));
    check("scrub_overflow", 64'(bus.scrub_overflow), 64'(e_ovf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 16'h0, 32'h0, 0, 16'h0, 32'h0);
  endtask

  initial begin
    logic dis_r;
    rst = 1'b1;
    bus.dccm_wr_block = 1'b0;
    bus.dec_tlu_core_ecc_disable = 1'b0;
    bus.stbuf_wr_req = 1'b0;
    bus.stbuf_wr_addr = '0;
    bus.stbuf_wr_data = '0;
    bus.sec_valid_dc3 = 1'b0;
    bus.sec_addr_dc3 = '0;
    bus.sec_data_dc3 = '0;

    step(1, 0, 0, 0, 16'h0, 32'h0, 0, 16'h0, 32'h0);
    step(1, 0, 0, 0, 16'h0, 32'h0, 0, 16'h0, 32'h0);

    // store write straight after reset
    step(0, 0, 0, 1, 16'h0040, 32'h0, 0, 16'h0, 32'h0);
    idle(1);

    // single scrub capture and writeback
    step(0, 0, 0, 0, 16'h0, 32'h0, 1, 16'h0100, 32'hDEADBEEF);
    idle(3);

    // queue overflow while blocked, then drain
    step(0, 1, 0, 0, 16'h0, 32'h0, 1, 16'h0010, 32'h11111111);
    step(0, 1, 0, 0, 16'h0, 32'h0, 1, 16'h0020, 32'h22222222);
    step(0, 1, 0, 0, 16'h0, 32'h0, 1, 16'h0030, 32'h33333333);
    idle(4);

    // starvation: continuous captures against a held store request
    for (int i = 0; i < 12; i++)
      step(0, 0, 0, 1, 16'h0400, 32'hA5A50000 + i, 1, 16'h1000 + 16'(i * 4), 32'h5A5A0000 + i);
    idle(4);

    // capture colliding with a same-cycle store grant, then duplicate capture
    step(0, 0, 0, 1, 16'h0200, 32'hCAFEF00D, 1, 16'h0200, 32'h12345678);
    step(0, 1, 0, 0, 16'h0, 32'h0, 1, 16'h0300, 32'h0BADC0DE);
    step(0, 1, 0, 0, 16'h0, 32'h0, 1, 16'h0300, 32'h0BADC0DE);
    idle(3);

    // ECC disabled: no capture, zero ECC field
    step(0, 0, 1, 0, 16'h0, 32'h0, 1, 16'h0500, 32'h87654321);
    step(0, 0, 1, 1, 16'h0600, 32'hFFFFFFFF, 0, 16'h0, 32'h0);
    idle(1);

    // reset with two entries queued
    step(0, 1, 0, 0, 16'h0, 32'h0, 1, 16'h0700, 32'h01010101);
    step(0, 1, 0, 0, 16'h0, 32'h0, 1, 16'h0704, 32'h02020202);
    step(1, 0, 0, 0, 16'h0, 32'h0, 0, 16'h0, 32'h0);
    idle(2);

    // random traffic over a small address pool to provoke collisions
    dis_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) dis_r = ~dis_r;
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 99) < 20,
           dis_r,
           $urandom_range(0, 99) < 55,
           16'h0100 + 16'($urandom_range(0, 7) * 4),
           32'($urandom),
           $urandom_range(0, 99) < 45,
           16'h0100 + 16'($urandom_range(0, 7) * 4),
           32'($urandom));
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
